ltch_fifo_ctrl: RTL

Write/read controller for a latch-based FIFO built from `DEPTH` instances of the `ltch` primitive, one per entry. It accepts words on a valid/ready input and drives each latch's `en` and `data_i` from flops only, so the enables are glitch-free and the data is stable for the whole transparent window. It presents the oldest latched entry on a valid/ready output. It sits directly upstream of the latch array, which feeds its `data_o` buses back through `rdata_i`.

---
 rtl/ltch_fifo_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ltch_fifo_ctrl.sv
// rtl/ltch_fifo_ctrl.sv - write/read controller for a latch-based FIFO of DEPTH ltch entries
// Optional X/protocol checkers: define LTCH_FIFO_XCHK_EN (simulation only).
module ltch_fifo_ctrl #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter     NAME  = "ltch_fifo"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  output logic [DEPTH-1:0]      wen_o,
  output logic [DW-1:0]         wdata_o,
  input  logic [DEPTH*DW-1:0]   rdata_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_HOLD} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [DEPTH-1:0]  r_wen;
  logic [DW-1:0]     r_wdata;
  logic              w_accept;
  logic              w_pop;
  logic              w_inc;
  logic [DEPTH-1:0]  w_wen_onehot;

  assign in_ready     = (r_state != S_WRITE) && (r_count < CW'(DEPTH));
  assign w_accept     = in_valid & in_ready;
  assign out_valid    = (r_count != '0);
  assign w_pop        = out_valid & out_ready;
  assign w_inc        = (r_state == S_WRITE);
  assign w_wen_onehot = {{(DEPTH-1){1'b0}}, 1'b1} << r_wptr;

  assign wen_o    = r_wen;
  assign wdata_o  = r_wdata;
  assign count    = r_count;
  assign out_data = rdata_i[r_rptr*DW +: DW];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_HOLD;
      S_HOLD:  w_state_nxt = w_accept ? S_WRITE : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wen   <= '0;
      r_wdata <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      // wdata only moves together with a rising enable, so the latch closes on stable data
      if (w_accept) begin
        r_wen   <= w_wen_onehot;
        r_wdata <= in_data;
      end else if (w_inc) begin
        r_wen   <= '0;
      end
      if (w_inc) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_inc, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef LTCH_FIFO_XCHK_EN
  logic [DEPTH-1:0] q_wen;
  logic [DW-1:0]    q_wdata;

  xchecker_logic #(.W(1),     .NAME({"in_valid of ", NAME}))  u_xchk_in_valid  (.clk(clk), .rst_n(rst_n), .i_sig(in_valid));
  xchecker_logic #(.W(1),     .NAME({"out_ready of ", NAME})) u_xchk_out_ready (.clk(clk), .rst_n(rst_n), .i_sig(out_ready));
  xchecker_logic #(.W(DEPTH), .NAME({"wen_o of ", NAME}))     u_xchk_wen       (.clk(clk), .rst_n(rst_n), .i_sig(r_wen));

  always @(posedge clk) begin
    if (rst_n) begin
      if ($countones(r_wen) > 1) $error("%s: more than one latch enable set", NAME);
      if ((q_wen != '0) && (r_wen == '0) && (r_wdata != q_wdata))
        $error("%s: write data changed while enable fell", NAME);
    end
    q_wen   <= r_wen;
    q_wdata <= r_wdata;
  end
`endif

endmodule

`ifdef LTCH_FIFO_XCHK_EN
module xchecker_logic #(
  parameter int W    = 1,
  parameter     NAME = "xchk"
) (
  input logic         clk,
  input logic         rst_n,
  input logic [W-1:0] i_sig
);
  always @(posedge clk) begin
    if (rst_n && $isunknown(i_sig)) $error("%s: unknown value", NAME);
  end
endmodule
`endif
